// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the receive FIFO and its consumer.
// The slave modport is the FIFO side; the master modport is the receiver/consumer side.
interface uart_rx_fifo_if #(
   parameter int P_UART_DATA_WIDTH = 8,
   parameter int P_ADDR_WIDTH      = 4
);
   logic [P_UART_DATA_WIDTH-1:0] i_uart_rx_data;
   logic                         i_uart_rx_valid;
   logic [P_UART_DATA_WIDTH-1:0] o_fifo_data;
   logic                         o_fifo_valid;
   logic                         i_fifo_ready;
   logic [P_ADDR_WIDTH:0]        o_fifo_count;
   logic                         o_fifo_full;
   logic                         o_fifo_empty;
   logic                         o_overflow;
   logic                         i_overflow_clr;

   modport slave (
      input  i_uart_rx_data, i_uart_rx_valid, i_fifo_ready, i_overflow_clr,
      output o_fifo_data, o_fifo_valid, o_fifo_count, o_fifo_full, o_fifo_empty, o_overflow
   );

   modport master (
      output i_uart_rx_data, i_uart_rx_valid, i_fifo_ready, i_overflow_clr,
      input  o_fifo_data, o_fifo_valid, o_fifo_count, o_fifo_full, o_fifo_empty, o_overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: captures single-cycle rx pulses,
// presents the head word show-ahead over valid/ready, reports fill level and a
// sticky overflow flag. Status outputs depend only on registered state.
module uart_rx_fifo #(
   parameter int P_UART_DATA_WIDTH = 8,
   parameter int P_FIFO_DEPTH      = 16,
   parameter int P_ADDR_WIDTH      = 4
) (
   input logic           i_u_clk,
   input logic           i_u_rst,
   uart_rx_fifo_if.slave bus
);

   // Extra MSB on each pointer is the wrap bit that separates full from empty.
   logic [P_ADDR_WIDTH:0]        wr_ptr;
   logic [P_ADDR_WIDTH:0]        rd_ptr;
   logic [P_UART_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
   logic                         overflow;
   logic                         full;
   logic                         empty;
   logic                         push;
   logic                         pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[P_ADDR_WIDTH] != rd_ptr[P_ADDR_WIDTH]) &&
                  (wr_ptr[P_ADDR_WIDTH-1:0] == rd_ptr[P_ADDR_WIDTH-1:0]);

   // A pop frees a slot in the same cycle, so a push into a full FIFO is legal
   // when the consumer is also taking the head word.
   assign pop  = !empty && bus.i_fifo_ready;
   assign push = bus.i_uart_rx_valid && (!full || pop);

   // Pointer and sticky-overflow update; a dropped word leaves pointers alone.
   always_ff @(posedge i_u_clk) begin
      if (i_u_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         // Setting takes priority over a simultaneous clear.
         if (bus.i_uart_rx_valid && !push)
            overflow <= 1'b1;
         else if (bus.i_overflow_clr)
            overflow <= 1'b0;
      end
   end

   // Storage write; cleared on reset so the head word reads 0 after a flush.
   always_ff @(posedge i_u_clk) begin
      if (i_u_rst) begin
         for (int i = 0; i < P_FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr[P_ADDR_WIDTH-1:0]] <= bus.i_uart_rx_data;
      end
   end

   assign bus.o_fifo_data  = mem[rd_ptr[P_ADDR_WIDTH-1:0]];
   assign bus.o_fifo_valid = !empty;
   assign bus.o_fifo_empty = empty;
   assign bus.o_fifo_full  = full;
   assign bus.o_fifo_count = wr_ptr - rd_ptr;
   assign bus.o_overflow   = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a directed vector table, hand-written full/overflow/
// reset sequences, and random traffic checked against a queue-based model.
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_rx_fifo_if #(.P_UART_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) bus ();

   uart_rx_fifo #(
      .P_UART_DATA_WIDTH(DW),
      .P_FIFO_DEPTH(DEPTH),
      .P_ADDR_WIDTH(AW)
   ) dut (
      .i_u_clk(clk),
      .i_u_rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a queue plus the sticky flag.
   logic [DW-1:0] q[$];
   bit            m_ovf;
   int            n_chk  = 0;
   int            n_fail = 0;

   typedef struct {
      bit            v;
      logic [DW-1:0] d;
      bit            r;
      bit            c;
      int            e_cnt;
      bit            e_vld;
      logic [DW-1:0] e_data;
      bit            e_full;
      bit            e_ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_count"}, int'(bus.o_fifo_count), q.size());
      chk({tag, "_empty"}, int'(bus.o_fifo_empty), int'(q.size() == 0));
      chk({tag, "_full"},  int'(bus.o_fifo_full),  int'(q.size() == DEPTH));
      chk({tag, "_valid"}, int'(bus.o_fifo_valid), int'(q.size() != 0));
      chk({tag, "_ovf"},   int'(bus.o_overflow),   int'(m_ovf));
      if (q.size() != 0) chk({tag, "_data"}, int'(bus.o_fifo_data), int'(q[0]));
   endtask

   // One clock: drive inputs, advance the model, step, check.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r, input bit c,
                        input string tag);
      bit do_pop, do_push;
      bus.i_uart_rx_valid = v;
      bus.i_uart_rx_data  = d;
      bus.i_fifo_ready    = r;
      bus.i_overflow_clr  = c;
      do_pop  = (q.size() != 0) && r;
      do_push = v && ((q.size() < DEPTH) || do_pop);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
      if (v && !do_push) m_ovf = 1'b1;
      else if (c)        m_ovf = 1'b0;
      @(posedge clk);
      #1;
      bus.i_uart_rx_valid = 1'b0;
      bus.i_fifo_ready    = 1'b0;
      bus.i_overflow_clr  = 1'b0;
      check_model(tag);
   endtask

   task automatic do_reset(input bit noise);
      rst = 1'b1;
      bus.i_uart_rx_valid = noise;
      bus.i_uart_rx_data  = 8'hEE;
      bus.i_fifo_ready    = noise;
      bus.i_overflow_clr  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_uart_rx_valid = 1'b0;
      bus.i_fifo_ready    = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      chk("rst_count", int'(bus.o_fifo_count), 0);
      chk("rst_empty", int'(bus.o_fifo_empty), 1);
      chk("rst_full",  int'(bus.o_fifo_full),  0);
      chk("rst_valid", int'(bus.o_fifo_valid), 0);
      chk("rst_ovf",   int'(bus.o_overflow),   0);
      chk("rst_data",  int'(bus.o_fifo_data),  0);
   endtask

   task automatic fill(input logic [DW-1:0] base, input string tag);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, base + DW'(i), 1'b0, 1'b0, tag);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushes;
      int iters;
      // v, d, r, c, e_cnt, e_vld, e_data, e_full, e_ovf
      vecs[0] = '{1, 8'h55, 0, 0, 1, 1, 8'h55, 0, 0};
      vecs[1] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0};
      vecs[2] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0};
      vecs[3] = '{1, 8'h12, 1, 0, 1, 1, 8'h12, 0, 0};
      vecs[4] = '{1, 8'h34, 0, 0, 2, 1, 8'h12, 0, 0};
      vecs[5] = '{0, 8'h00, 0, 0, 2, 1, 8'h12, 0, 0};
      vecs[6] = '{1, 8'h56, 1, 0, 2, 1, 8'h34, 0, 0};
      vecs[7] = '{0, 8'h00, 1, 0, 1, 1, 8'h56, 0, 0};
      vecs[8] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0};
      vecs[9] = '{0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0};

      bus.i_uart_rx_valid = 1'b0;
      bus.i_uart_rx_data  = '0;
      bus.i_fifo_ready    = 1'b0;
      bus.i_overflow_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);

      // T1: directed vectors, each checked against the table and the model.
      foreach (vecs[i]) begin
         cycle(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c, "t1");
         chk("t1_tab_count", int'(bus.o_fifo_count), vecs[i].e_cnt);
         chk("t1_tab_valid", int'(bus.o_fifo_valid), int'(vecs[i].e_vld));
         chk("t1_tab_full",  int'(bus.o_fifo_full),  int'(vecs[i].e_full));
         chk("t1_tab_ovf",   int'(bus.o_overflow),   int'(vecs[i].e_ovf));
         if (vecs[i].e_vld) chk("t1_tab_data", int'(bus.o_fifo_data), int'(vecs[i].e_data));
      end

      // T2: fill to full, then drain in order.
      fill(8'h00, "t2_fill");
      chk("t2_full",  int'(bus.o_fifo_full),  1);
      chk("t2_count", int'(bus.o_fifo_count), 16);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t2_order", int'(bus.o_fifo_data), i);
         cycle(1'b0, '0, 1'b1, 1'b0, "t2_drain");
      end
      chk("t2_empty", int'(bus.o_fifo_empty), 1);

      // T3: overflow while full, clear, then clear colliding with overflow.
      fill(8'h20, "t3_fill");
      cycle(1'b1, 8'hAA, 1'b0, 1'b0, "t3_ovf");
      chk("t3_ovf_set",   int'(bus.o_overflow),   1);
      chk("t3_ovf_count", int'(bus.o_fifo_count), 16);
      cycle(1'b0, '0, 1'b0, 1'b1, "t3_clr");
      chk("t3_ovf_clr", int'(bus.o_overflow), 0);
      cycle(1'b1, 8'hCC, 1'b0, 1'b1, "t3_setwins");
      chk("t3_set_wins", int'(bus.o_overflow), 1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t3_order", int'(bus.o_fifo_data), 8'h20 + i);
         cycle(1'b0, '0, 1'b1, 1'b0, "t3_drain");
      end
      chk("t3_empty", int'(bus.o_fifo_empty), 1);
      cycle(1'b0, '0, 1'b0, 1'b1, "t3_clr2");

      // T4: push into a full FIFO while popping.
      fill(8'h40, "t4_fill");
      cycle(1'b1, 8'hBB, 1'b1, 1'b0, "t4_pushpop");
      chk("t4_no_ovf", int'(bus.o_overflow),   0);
      chk("t4_count",  int'(bus.o_fifo_count), 16);
      for (int i = 1; i < DEPTH; i++) begin
         chk("t4_order", int'(bus.o_fifo_data), 8'h40 + i);
         cycle(1'b0, '0, 1'b1, 1'b0, "t4_drain");
      end
      chk("t4_last", int'(bus.o_fifo_data), 8'hBB);
      cycle(1'b0, '0, 1'b1, 1'b0, "t4_drain");
      chk("t4_empty", int'(bus.o_fifo_empty), 1);

      // T5: random traffic against the model.
      pushes = 0;
      iters  = 0;
      while (pushes < 40 && iters < 1000) begin
         bit v, r, c;
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) == 0);
         c = ($urandom_range(0, 15) == 0);
         if (v) pushes++;
         cycle(v, DW'($urandom), r, c, "t5");
         iters++;
      end
      chk("t5_pushes", pushes, 40);
      while (q.size() != 0 && iters < 1100) begin
         cycle(1'b0, '0, 1'b1, 1'b0, "t5_drain");
         iters++;
      end
      chk("t5_drained", int'(bus.o_fifo_empty), 1);

      // T6: reset mid-stream with count=7 and overflow set; inputs active during reset.
      cycle(1'b0, '0, 1'b0, 1'b1, "t6_clr");
      fill(8'h60, "t6_fill");
      cycle(1'b1, 8'h99, 1'b0, 1'b0, "t6_ovf");
      for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b0, "t6_pop");
      chk("t6_pre_count", int'(bus.o_fifo_count), 7);
      chk("t6_pre_ovf",   int'(bus.o_overflow),   1);
      do_reset(1'b1);
      cycle(1'b1, 8'h77, 1'b0, 1'b0, "t6_after");
      chk("t6_after_data", int'(bus.o_fifo_data), 8'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
